// File: rtl/sm83_reg_pc_in.sv
// SM83 program counter load side: incrementer, two-byte operand staging, 16-bit load and RST/IRQ vectors.
// Optional halt-bug increment suppression is enabled by defining SM83_PC_HALT_BUG_EN.
module sm83_reg_pc_in #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic [7:0]  db_in,
  input  logic        db_lo_wr,
  input  logic        db_hi_wr,
  input  logic        commit,
  input  logic [15:0] abus_in,
  input  logic        abus_ld,
  input  logic [2:0]  vec_sel,
  input  logic        rst_ld,
  input  logic        irq_ld,
  input  logic        halt_bug,
  output logic [15:0] pc,
  output logic [1:0]  stage_state,
  output logic        seq_err,
  output logic        hb_armed
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FULL = 2'd3
  } stage_t;

  stage_t      state;
  stage_t      wr_state;
  logic [7:0]  stg_lo;
  logic [7:0]  stg_hi;
  logic [15:0] vec_off;
  logic        any_wr;
  logic        hb_suppress;

  assign any_wr      = db_lo_wr | db_hi_wr;
  assign vec_off     = {10'd0, vec_sel, 3'b000};
  assign stage_state = state;

`ifdef SM83_PC_HALT_BUG_EN
  // A same-cycle halt_bug re-arms instead of consuming the pending suppression.
  assign hb_suppress = hb_armed & ~halt_bug;
`else
  logic unused_halt_bug;
  assign unused_halt_bug = halt_bug;
  assign hb_suppress     = 1'b0;
`endif

  // Staging state after byte writes when nothing outranks them.
  always_comb begin
    wr_state = state;
    unique case (state)
      ST_IDLE: begin
        if (db_lo_wr && db_hi_wr) wr_state = ST_FULL;
        else if (db_lo_wr)        wr_state = ST_LO;
        else if (db_hi_wr)        wr_state = ST_HI;
      end
      ST_LO:   if (db_hi_wr) wr_state = ST_FULL;
      ST_HI:   if (db_lo_wr) wr_state = ST_FULL;
      ST_FULL: wr_state = ST_FULL;
      default: wr_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      state    <= ST_IDLE;
      stg_lo   <= 8'h00;
      stg_hi   <= 8'h00;
      seq_err  <= 1'b0;
      hb_armed <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (irq_ld) begin
        pc    <= 16'h0040 + vec_off;
        state <= ST_IDLE;
      end else if (rst_ld) begin
        pc    <= vec_off;
        state <= ST_IDLE;
      end else if (abus_ld) begin
        pc    <= abus_in;
        state <= ST_IDLE;
      end else if (commit) begin
        // Commit always uses pre-edge staging; any same-cycle byte write is dropped.
        if (state == ST_FULL) pc <= {stg_hi, stg_lo};
        seq_err <= (state != ST_FULL) | any_wr;
        state   <= ST_IDLE;
      end else begin
        if (inc && !hb_suppress) pc <= pc + 16'd1;
        if (db_lo_wr) stg_lo <= db_in;
        if (db_hi_wr) stg_hi <= db_in;
        state <= wr_state;
      end

`ifdef SM83_PC_HALT_BUG_EN
      if (halt_bug)                             hb_armed <= 1'b1;
      else if (irq_ld | rst_ld | abus_ld | commit) hb_armed <= 1'b0;
      else if (inc)                             hb_armed <= 1'b0;
`else
      hb_armed <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_sm83_reg_pc_in.sv
// Scoreboard bench for sm83_reg_pc_in: directed test-plan sequences then randomized traffic vs a behavioural model.
module tb_sm83_reg_pc_in;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, inc, db_lo_wr, db_hi_wr, commit, abus_ld, rst_ld, irq_ld, halt_bug;
  logic [7:0]  db_in;
  logic [15:0] abus_in;
  logic [2:0]  vec_sel;
  logic [15:0] pc;
  logic [1:0]  stage_state;
  logic        seq_err, hb_armed;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  st;
    logic        err;
    logic        hb;
  } exp_t;

  exp_t q[$];

  // Behavioural model state
  int m_pc = 0;
  bit m_have_lo = 0, m_have_hi = 0;
  int m_slo = 0, m_shi = 0;
  bit m_hb = 0;

  always #5 clk = ~clk;

  sm83_reg_pc_in #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .inc(inc), .db_in(db_in), .db_lo_wr(db_lo_wr),
    .db_hi_wr(db_hi_wr), .commit(commit), .abus_in(abus_in), .abus_ld(abus_ld),
    .vec_sel(vec_sel), .rst_ld(rst_ld), .irq_ld(irq_ld), .halt_bug(halt_bug),
    .pc(pc), .stage_state(stage_state), .seq_err(seq_err), .hb_armed(hb_armed)
  );

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every edge with a pending expectation gets compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("pc", int'(pc), int'(e.pc));
      cmp("stage_state", int'(stage_state), int'(e.st));
      cmp("seq_err", int'(seq_err), int'(e.err));
      cmp("hb_armed", int'(hb_armed), int'(e.hb));
    end
  end

  task automatic model_step();
    exp_t e;
    bit err = 0;
    bit full;
    bit outranked;
    if (reset) begin
      m_pc = int'(RESET_PC);
      m_have_lo = 0; m_have_hi = 0;
      m_slo = 0; m_shi = 0;
      m_hb = 0;
    end else begin
      full = m_have_lo && m_have_hi;
      outranked = irq_ld || rst_ld || abus_ld || commit;
      if (irq_ld) m_pc = 64 + 8 * int'(vec_sel);
      else if (rst_ld) m_pc = 8 * int'(vec_sel);
      else if (abus_ld) m_pc = int'(abus_in);
      else if (commit) begin
        if (full) m_pc = m_shi * 256 + m_slo;
        err = !full || db_lo_wr || db_hi_wr;
      end else begin
`ifdef SM83_PC_HALT_BUG_EN
        if (inc && !(m_hb && !halt_bug)) m_pc = (m_pc + 1) % 65536;
`else
        if (inc) m_pc = (m_pc + 1) % 65536;
`endif
        if (db_lo_wr) begin m_slo = int'(db_in); m_have_lo = 1; end
        if (db_hi_wr) begin m_shi = int'(db_in); m_have_hi = 1; end
      end
      if (outranked) begin m_have_lo = 0; m_have_hi = 0; end
`ifdef SM83_PC_HALT_BUG_EN
      if (halt_bug) m_hb = 1;
      else if (outranked || inc) m_hb = 0;
`endif
    end
    e.pc  = 16'(m_pc);
    e.st  = m_have_hi ? (m_have_lo ? 2'd3 : 2'd2) : (m_have_lo ? 2'd1 : 2'd0);
    e.err = err;
    e.hb  = m_hb;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    reset = 0; inc = 0; db_in = 8'h00; db_lo_wr = 0; db_hi_wr = 0; commit = 0;
    abus_in = 16'h0000; abus_ld = 0; vec_sel = 3'd0; rst_ld = 0; irq_ld = 0; halt_bug = 0;
  endtask

  // Apply the current inputs for one edge; returns 2 time units after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #2;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #2;
    reset = 1; cyc();
    reset = 1; cyc();
    cmp("reset_pc", int'(pc), int'(RESET_PC));
    cmp("reset_stage", int'(stage_state), 0);

    repeat (3) begin inc = 1; cyc(); end
    cmp("inc3", int'(pc), 16'h0003);
    abus_in = 16'hFFFF; abus_ld = 1; cyc();
    inc = 1; cyc();
    cmp("wrap", int'(pc), 16'h0000);

    db_in = 8'h34; db_lo_wr = 1; cyc();
    cyc();
    db_in = 8'h12; db_hi_wr = 1; cyc();
    cmp("full_stage", int'(stage_state), 3);
    commit = 1; cyc();
    cmp("commit_pc", int'(pc), 16'h1234);
    cmp("commit_err", int'(seq_err), 0);

    db_in = 8'h99; db_lo_wr = 1; cyc();
    commit = 1; cyc();
    cmp("bad_commit_pc", int'(pc), 16'h1234);
    cmp("bad_commit_err", int'(seq_err), 1);
    cyc();
    cmp("err_one_cycle", int'(seq_err), 0);

    irq_ld = 1; rst_ld = 1; abus_ld = 1; abus_in = 16'hBEEF; commit = 1; inc = 1; vec_sel = 3'd2; cyc();
    cmp("irq_prio", int'(pc), 16'h0050);
    rst_ld = 1; vec_sel = 3'd7; cyc();
    cmp("rst7", int'(pc), 16'h0038);

    abus_in = 16'h0100; abus_ld = 1; cyc();
    halt_bug = 1; cyc();
    inc = 1; cyc();
`ifdef SM83_PC_HALT_BUG_EN
    cmp("hb_inc1", int'(pc), 16'h0100);
`else
    cmp("hb_inc1", int'(pc), 16'h0101);
`endif
    inc = 1; cyc();
`ifdef SM83_PC_HALT_BUG_EN
    cmp("hb_inc2", int'(pc), 16'h0101);
`else
    cmp("hb_inc2", int'(pc), 16'h0102);
`endif

    db_in = 8'h55; db_lo_wr = 1; cyc();
    reset = 1; commit = 1; cyc();
    cmp("reset_mid_pc", int'(pc), int'(RESET_PC));
    cmp("reset_mid_stage", int'(stage_state), 0);
    cmp("reset_mid_err", int'(seq_err), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      irq_ld   = ($urandom_range(0, 19) == 0);
      rst_ld   = ($urandom_range(0, 19) == 0);
      abus_ld  = ($urandom_range(0, 14) == 0);
      commit   = ($urandom_range(0, 5) == 0);
      inc      = ($urandom_range(0, 1) == 0);
      db_lo_wr = ($urandom_range(0, 2) == 0);
      db_hi_wr = ($urandom_range(0, 2) == 0);
      halt_bug = ($urandom_range(0, 15) == 0);
      db_in    = 8'($urandom);
      abus_in  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      vec_sel  = 3'($urandom);
      cyc();
    end

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm83_reg_pc_in.md
# sm83_reg_pc_in

Load side of the SM83 program counter. Holds the 16-bit PC and updates it on one clock from four sources: the incrementer, a two-byte staging path fed from the 8-bit internal data bus (JP/CALL/RET operands), a full 16-bit load from the address-side bus (JP HL, computed JR), and fixed RST/interrupt vectors. It feeds the PC bus-output driver cells, which only read `pc`.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value after reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inc`  in  1  PC <= PC + 1.
- `db_in`  in  8  data-bus byte for staging.
- `db_lo_wr`  in  1  write `db_in` to staging low byte.
- `db_hi_wr`  in  1  write `db_in` to staging high byte.
- `commit`  in  1  PC <= staging; requires both staging bytes.
- `abus_in`  in  16  full PC value.
- `abus_ld`  in  1  PC <= `abus_in`.
- `vec_sel`  in  3  vector index n.
- `rst_ld`  in  1  PC <= {8'h00, n, 3'b000}, giving 0x00–0x38.
- `irq_ld`  in  1  PC <= 16'h0040 + 8*n, giving 0x40–0x78.
- `halt_bug`  in  1  arm one-shot increment suppression (see Configuration).
- `pc`  out  16  current PC, registered.
- `stage_state`  out  2  0 IDLE, 1 LO, 2 HI, 3 FULL.
- `seq_err`  out  1  one-cycle pulse on a protocol violation.
- `hb_armed`  out  1  halt-bug flag.

## Operation
- PC source priority: `reset` > `irq_ld` > `rst_ld` > `abus_ld` > `commit` > `inc`. The highest active source wins. Lower sources in the same cycle are discarded without error, except the commit case below.
- Staging FSM, with registers `stg_lo` and `stg_hi`:
  - IDLE: lo_wr → LO; hi_wr → HI; both together → FULL.
  - LO: hi_wr → FULL; lo_wr overwrites the low byte and stays in LO.
  - HI: lo_wr → FULL; hi_wr overwrites the high byte and stays in HI.
  - FULL: further writes overwrite the addressed byte and stay in FULL.
- `commit` in FULL loads PC with {stg_hi, stg_lo}; the FSM → IDLE.
- `commit` in IDLE, LO or HI: PC unchanged, `seq_err` pulses, FSM → IDLE.
- `commit` with a same-cycle byte write: commit uses the pre-edge staging. The write is dropped, `seq_err` pulses, FSM → IDLE.
- `irq_ld`, `rst_ld` or `abus_ld` → FSM IDLE, which abandons a partial operand. No error.
- A `commit` pre-empted by a higher-priority load raises no `seq_err`.
- Increment wraps modulo 2^16: 0xFFFF + 1 = 0x0000.
- `vec_sel` arithmetic is 16-bit; upper bits are always zero except as shown above.
- Staging registers hold their values after commit; only `stage_state` clears.

## Timing
- Every load and increment appears on `pc` the cycle after the enabling edge. There is no combinational path from inputs to `pc`.
- `stage_state`, `hb_armed` and `seq_err` are registered. `seq_err` is high for exactly one cycle per violation.
- Reset values: `pc` = `RESET_PC`, `stage_state` = IDLE, `stg_lo`/`stg_hi` = 0x00, `seq_err` = 0, `hb_armed` = 0.
- Reset asserted mid-operation, such as in a partial LO state, discards all staging and wins over every same-cycle input.
- Back-to-back commits need a fresh pair of byte writes in between. Otherwise the second commit is a violation.

## Configuration
- `SM83_PC_HALT_BUG_EN` defined:
  - `halt_bug` sets `hb_armed`.
  - The next cycle where `inc` is the winning source leaves PC unchanged and clears `hb_armed`.
  - Any higher-priority PC load also clears `hb_armed`.
  - `halt_bug` together with a winning `inc` in the same cycle: the increment happens and the flag is armed for the next one.
- `SM83_PC_HALT_BUG_EN` undefined: `halt_bug` is ignored, `hb_armed` is constant 0, and `inc` always increments. The port list is identical in both builds.

## Test plan
- Reset, then `inc` ×3 → `pc` = 0x0003. Load `abus_in`=0xFFFF, then `inc` → `pc` = 0x0000.
- `db_lo_wr` 0x34, a one-cycle gap, `db_hi_wr` 0x12, then `commit` → `pc` = 0x1234, `stage_state` 3→0, `seq_err` = 0.
- `db_lo_wr` only, then `commit` → `pc` unchanged, `seq_err` high exactly 1 cycle, `stage_state` = IDLE.
- `irq_ld`, `rst_ld`, `abus_ld`, `commit` and `inc` all together with `vec_sel`=2 → `pc` = 0x0050. Next cycle `rst_ld` with `vec_sel`=7 → `pc` = 0x0038.
- PC=0x0100 with the macro defined: pulse `halt_bug`, then `inc` twice → `pc` = 0x0100 then 0x0101. With the macro undefined → 0x0101 then 0x0102.
- State LO, then `reset` asserted together with `commit` → `pc` = `RESET_PC`, IDLE, no `seq_err`.
